// File: rtl/md5_candidate_generator.sv
// Brute-force candidate enumerator: walks every byte string in [min,max]^len for
// len = MIN_LEN..MAX_LEN as an odometer and emits each one as a padded MD5 block.
module md5_candidate_generator #(
    parameter int MIN_LEN = 1,
    parameter int MAX_LEN = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         run,
    input  logic [7:0]   min,
    input  logic [7:0]   max,
    output logic [511:0] chunk,
    output logic         valid,
    output logic         done,
    output logic [63:0]  count
);

    localparam int LEN_W   = 5;
    localparam int BYTES_W = MAX_LEN * 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [7:0]           r_min, w_min_nxt;
    logic [7:0]           r_max, w_max_nxt;
    logic [LEN_W-1:0]     r_len, w_len_nxt;
    logic [BYTES_W-1:0]   r_bytes, w_bytes_nxt;
    logic [63:0]          r_count, w_count_nxt;
    logic [511:0]         r_chunk;
    logic [BYTES_W-1:0]   w_bytes_inc;
    logic                 w_carry;
    logic                 w_load;

    // Candidate bytes first, then the 0x80 terminator, then the bit length.
    function automatic logic [511:0] build_chunk(input logic [BYTES_W-1:0] b,
                                                 input logic [LEN_W-1:0]   len);
        logic [511:0] c;
        c = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < len) c[8*i +: 8] = b[8*i +: 8];
        end
        for (int i = 0; i <= MAX_LEN; i++) begin
            if (LEN_W'(i) == len) c[8*i +: 8] = 8'h80;
        end
        c[479:448] = {24'd0, len, 3'b000};
        return c;
    endfunction

    // Odometer step over the active bytes; w_carry survives only if every byte was at max.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later statements see the
        // updated carry; every variable gets a default first so no latch is inferred.
        w_bytes_inc = r_bytes;
        w_carry     = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < r_len && w_carry) begin
                if (r_bytes[8*i +: 8] == r_max) begin
                    w_bytes_inc[8*i +: 8] = r_min;
                end else begin
                    w_bytes_inc[8*i +: 8] = r_bytes[8*i +: 8] + 8'd1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_max_nxt   = r_max;
        w_len_nxt   = r_len;
        w_bytes_nxt = r_bytes;
        w_count_nxt = r_count;
        w_load      = 1'b0;
        if (start) begin
            w_min_nxt = min;
            w_max_nxt = max;
            if (min > max) begin
                w_state_nxt = S_DONE;
                w_count_nxt = '0;
            end else begin
                w_state_nxt = S_RUN;
                w_len_nxt   = LEN_W'(MIN_LEN);
                w_bytes_nxt = {MAX_LEN{min}};
                w_count_nxt = 64'd1;
                w_load      = 1'b1;
            end
        end else if (r_state == S_RUN && run) begin
            if (!w_carry) begin
                w_bytes_nxt = w_bytes_inc;
                w_count_nxt = r_count + 64'd1;
                w_load      = 1'b1;
            end else if (r_len == LEN_W'(MAX_LEN)) begin
                // Exhausted: chunk keeps the last candidate.
                w_state_nxt = S_DONE;
            end else begin
                w_len_nxt   = r_len + 5'd1;
                w_bytes_nxt = {MAX_LEN{r_min}};
                w_count_nxt = r_count + 64'd1;
                w_load      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so all registers update
        // from the same pre-edge values.
        if (reset) begin
            r_state <= S_IDLE;
            r_min   <= '0;
            r_max   <= '0;
            r_len   <= '0;
            r_bytes <= '0;
            r_count <= '0;
            r_chunk <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_min   <= w_min_nxt;
            r_max   <= w_max_nxt;
            r_len   <= w_len_nxt;
            r_bytes <= w_bytes_nxt;
            r_count <= w_count_nxt;
            if (w_load) r_chunk <= build_chunk(w_bytes_nxt, w_len_nxt);
        end
    end

    assign chunk = r_chunk;
    assign valid = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign count = r_count;

endmodule

// File: tb/tb_md5_candidate_generator.sv
// Scoreboarded bench: the driver pushes expected blocks computed from the candidate
// ordinal; a monitor pops and compares whenever the DUT shows valid.
module tb_md5_candidate_generator;

    localparam int MIN_LEN = 1;
    localparam int MAX_LEN = 2;

    logic         clk = 1'b0;
    logic         reset, start, run;
    logic [7:0]   min, max;
    logic [511:0] chunk;
    logic         valid, done;
    logic [63:0]  count;

    md5_candidate_generator #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .run   (run),
        .min   (min),
        .max   (max),
        .chunk (chunk),
        .valid (valid),
        .done  (done),
        .count (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] chunk;
        logic [63:0]  count;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    // Reference model: 0 idle, 1 running, 2 done; candidate identified by ordinal.
    int     m_state = 0;
    longint m_n, m_total, m_count = 0;
    int     m_min, m_r;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint ipow(input longint b, input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    // Ordinal n -> (length, digits in base m_r, digit 0 least significant = byte 0).
    function automatic logic [511:0] cand_chunk(input longint n);
        int           l;
        longint       rem;
        logic [7:0]   blk [64];
        logic [31:0]  bits;
        logic [511:0] c;
        l   = MIN_LEN;
        rem = n;
        while (rem >= ipow(m_r, l)) begin
            rem -= ipow(m_r, l);
            l++;
        end
        for (int i = 0; i < 64; i++) blk[i] = 8'h00;
        for (int i = 0; i < l; i++) begin
            blk[i] = 8'(m_min + int'(rem % m_r));
            rem    = rem / m_r;
        end
        blk[l] = 8'h80;
        bits   = 32'(l * 8);
        for (int i = 0; i < 4; i++) blk[56 + i] = bits[8*i +: 8];
        for (int i = 0; i < 64; i++) c[8*i +: 8] = blk[i];
        return c;
    endfunction

    task automatic step(input bit s, input bit r, input bit rst,
                        input logic [7:0] mn, input logic [7:0] mx);
        start = s; run = r; reset = rst; min = mn; max = mx;
        if (rst) begin
            m_state = 0;
            m_count = 0;
        end else if (s) begin
            if (mn > mx) begin
                m_state = 2;
                m_count = 0;
            end else begin
                m_min   = int'(mn);
                m_r     = int'(mx) - int'(mn) + 1;
                m_total = 0;
                for (int l = MIN_LEN; l <= MAX_LEN; l++) m_total += ipow(m_r, l);
                m_n     = 0;
                m_count = 1;
                m_state = 1;
            end
        end else if (m_state == 1 && r) begin
            if (m_n == m_total - 1) begin
                m_state = 2;
            end else begin
                m_n++;
                m_count++;
            end
        end
        if (m_state == 1) sb.push_back('{cand_chunk(m_n), m_count});
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_done(input string name);
        int guard = 0;
        while (m_state == 1 && guard < 500) begin
            step(0, 1, 0, 8'($urandom), 8'($urandom));
            guard++;
        end
        check({name, "_bound"}, 512'(m_state), 512'd2);
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, 512'(valid), 512'd0);
        check({name, "_done"},  512'(done),  512'd0);
        check({name, "_count"}, 512'(count), 512'd0);
        check({name, "_chunk"}, chunk, 512'd0);
    endtask

    // Monitor: every cycle the DUT shows valid, one scoreboard entry must match.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_valid", 512'd1, 512'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_chunk", chunk, e.chunk);
                    check("sb_count", 512'(count), 512'(e.count));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] exp_c;
        logic [7:0]   mn, mx;

        // Reset, then run is ignored while idle.
        step(0, 1, 1, 8'h00, 8'hff);
        step(0, 1, 1, 8'h00, 8'hff);
        check_idle("reset");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h10, 8'h20);
        check_idle("idle_run");

        // "a","b","aa","ba","ab","bb" then done.
        step(1, 1, 0, 8'h61, 8'h62);
        exp_c = '0;
        exp_c[7:0]     = 8'h61;
        exp_c[15:8]    = 8'h80;
        exp_c[479:448] = 32'd8;
        check("first_a_chunk", chunk, exp_c);
        check("first_a_valid", 512'(valid), 512'd1);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 8'($urandom), 8'($urandom));
        check("ab_done",  512'(done),  512'd1);
        check("ab_valid", 512'(valid), 512'd0);
        check("ab_count", 512'(count), 512'd6);
        exp_c = '0;
        exp_c[15:0]    = 16'h6262;
        exp_c[23:16]   = 8'h80;
        exp_c[479:448] = 32'd16;
        check("ab_last_chunk", chunk, exp_c);
        step(0, 1, 0, 8'h00, 8'hff);
        step(0, 1, 0, 8'h00, 8'hff);
        check("done_hold_count", 512'(count), 512'd6);
        check("done_hold_done",  512'(done),  512'd1);

        // Run held low for 3 cycles mid-sequence.
        step(1, 1, 0, 8'h61, 8'h63);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 8'h00);
        check("hold_count", 512'(count), 512'd5);
        run_to_done("hold_resume");
        check("hold_total", 512'(count), 512'd12);

        // Illegal range.
        step(1, 1, 0, 8'h7a, 8'h61);
        check("illegal_done",  512'(done),  512'd1);
        check("illegal_valid", 512'(valid), 512'd0);
        check("illegal_count", 512'(count), 512'd0);

        // Start together with reset, then restart and reset mid-run.
        step(1, 1, 1, 8'h61, 8'h62);
        check_idle("start_reset");
        step(1, 1, 0, 8'h61, 8'h62);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 8'h00);
        step(1, 1, 0, 8'h41, 8'h43);
        check("restart_count", 512'(count), 512'd1);
        check("restart_byte0", 512'(chunk[15:0]), 512'h8041);
        step(0, 1, 0, 8'h00, 8'h00);
        step(0, 1, 0, 8'h00, 8'h00);
        step(0, 1, 1, 8'h00, 8'h00);
        step(0, 1, 0, 8'h00, 8'h00);
        step(0, 1, 0, 8'h00, 8'h00);
        check_idle("reset_mid_run");

        // min == max: one candidate per length.
        step(1, 1, 0, 8'h55, 8'h55);
        run_to_done("single");
        check("single_count", 512'(count), 512'(MAX_LEN - MIN_LEN + 1));

        // Randomized rounds.
        for (int round = 0; round < 25; round++) begin
            mn = 8'($urandom_range(1, 200));
            if ($urandom_range(0, 5) == 0) mx = mn - 8'($urandom_range(1, 1));
            else                           mx = mn + 8'($urandom_range(0, 3));
            step(1, 1'($urandom_range(0, 1)), 0, mn, mx);
            for (int c = 0; c < 60 && m_state == 1; c++) begin
                if ($urandom_range(0, 40) == 0) begin
                    mn = 8'($urandom_range(1, 200));
                    mx = mn + 8'($urandom_range(0, 2));
                    step(1, 1, 0, mn, mx);
                end else begin
                    step(0, 1'($urandom_range(0, 3) != 0), 0, 8'($urandom), 8'($urandom));
                end
            end
            check("rnd_count", 512'(count), 512'(m_count));
            check("rnd_done",  512'(done),  512'(m_state == 2));
            check("rnd_valid", 512'(valid), 512'(m_state == 1));
        end

        step(0, 0, 1, 8'h00, 8'h00);
        step(0, 0, 0, 8'h00, 8'h00);
        check_idle("final_reset");
        check("sb_drained", 512'(sb.size()), 512'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md5_candidate_generator.md
MD5_CANDIDATE_GENERATOR -- requirements
Module: md5_candidate_generator

Interface
REQ-001 SHALL have parameter MIN_LEN, default 1: shortest candidate length in bytes, legal range 1..MAX_LEN.
REQ-002 SHALL have parameter MAX_LEN, default 8: longest candidate length in bytes, legal range 1..16.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse; latches min/max and restarts enumeration.
REQ-006 SHALL have port run  input  1  high = advance one candidate per cycle; low = hold.
REQ-007 SHALL have port min  input  8  lowest byte value, inclusive.
REQ-008 SHALL have port max  input  8  highest byte value, inclusive.
REQ-009 SHALL have port chunk  output  512  registered, padded MD5 block of the current candidate.
REQ-010 SHALL have port valid  output  1  chunk holds a candidate not yet superseded.
REQ-011 SHALL have port done  output  1  key space exhausted or range illegal.
REQ-012 SHALL have port count  output  64  number of candidates emitted since the last start.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 On start in any state, SHALL latch min/max, set length=MIN_LEN, set every used byte to latched min, set count=1, and enter RUN with valid=1 on the next cycle.
REQ-015 SHALL, on start with min>max, enter DONE with valid=0, done=1 and count=0.
REQ-016 SHALL, in RUN with run=1, advance the candidate as an odometer: byte 0 increments fastest; a byte at max wraps to min and carries into the next byte.
REQ-017 SHALL, when all bytes of the current length are at max and run=1, increase length by 1 and reset all bytes to min.
REQ-018 SHALL, when length=MAX_LEN and all bytes are at max and run=1, enter DONE with valid=0 and done=1, leaving chunk at the last candidate.
REQ-019 SHALL increment count by 1 on each advance; count wraps modulo 2^64.
REQ-020 SHALL, with run=0, hold chunk, count, valid and state unchanged.
REQ-021 SHALL give start priority over run when both are asserted in the same cycle.
REQ-022 SHALL ignore run in IDLE and in DONE.
REQ-023 SHALL ignore changes on min/max except at start.
REQ-024 SHALL format chunk as follows: candidate byte i at chunk[8i+7:8i] for i<length; 0x80 at byte index length; bits [479:448] = length*8; all other bits 0.
REQ-025 SHALL, with min==max, emit exactly one candidate per length, MAX_LEN-MIN_LEN+1 in total.
REQ-026 SHALL place the next candidate on chunk one cycle after each advancing edge; latency start->first chunk is 1 cycle.

Reset
REQ-027 SHALL, on reset, set chunk=0, valid=0, done=0, count=0 and state=IDLE, and clear the latched min/max and candidate bytes.
REQ-028 SHALL give reset priority over start and run.
REQ-029 SHALL abort a reset asserted mid-RUN without emitting a further valid candidate; a new start is required to resume.

Verification
REQ-030 Bench SHALL cover: reset -> chunk=0, valid=0, done=0, count=0, no change under run=1 until start.
REQ-031 Bench SHALL cover: MIN_LEN=1, MAX_LEN=2, min=0x61, max=0x62, start then run=1 -> "a","b","aa","ba","ab","bb" on consecutive cycles, then done=1, valid=0, count=6.
REQ-032 Bench SHALL cover: first candidate "a" -> chunk[7:0]=0x61, chunk[15:8]=0x80, chunk[479:448]=8, all other bits 0.
REQ-033 Bench SHALL cover: run toggled low for 3 cycles mid-sequence -> chunk and count frozen; the sequence resumes unchanged with no candidate skipped or repeated.
REQ-034 Bench SHALL cover: start with min=0x7a, max=0x61 -> DONE next cycle, done=1, valid=0, count=0.
REQ-035 Bench SHALL cover: start and reset in the same cycle -> reset values; then start alone mid-RUN -> enumeration restarts at length MIN_LEN, all bytes min, count=1.
